fwd_axis_egress: RTL and testbench

//  Reader end of the forwarder interface of parallel_cores/packetfilter_core. Claims accepted

---
 rtl/fwd_axis_egress_pkg.sv | 21 ++
 rtl/fwd_egress_fifo.sv | 50 +++++
 rtl/fwd_axis_egress.sv | 137 +++++++++++++
 tb/tb_fwd_axis_egress.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_axis_egress_pkg.sv
// Shared helpers and FSM state encoding for the forwarder-to-AXI-Stream egress.
package fwd_axis_egress_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_LEN,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fwd_egress_fifo.sv
// First-word-fall-through sync FIFO holding reordered beats with their keep/last tags.
module fwd_egress_fifo
  import fwd_axis_egress_pkg::*;
#(
  parameter int WIDTH = 73,
  parameter int DEPTH = 4,
  localparam int PW = clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_pop   = pop && !empty;
  // Head word is presented combinationally; zero while empty so outputs stay clean.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fwd_axis_egress.sv
// Claims packets from the packet-filter core, reads them out word by word and emits AXI-Stream frames.
module fwd_axis_egress
  import fwd_axis_egress_pkg::*;
#(
  parameter int PACKET_MEM_BYTES  = 2048,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4,
  localparam int DW = SN_FWD_DATA_WIDTH,
  localparam int BW = DW / 8,
  localparam int AW = clog2(PACKET_MEM_BYTES) - clog2(BW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_for_fwd,
  output logic                  rdy_for_fwd_ack,
  input  logic [PLEN_WIDTH-1:0] fwd_byte_len,
  output logic [AW-1:0]         fwd_addr,
  output logic                  fwd_rd_en,
  input  logic [DW-1:0]         fwd_rd_data,
  input  logic                  fwd_rd_data_vld,
  output logic                  fwd_done,
  output logic [DW-1:0]         m_axis_tdata,
  output logic [BW-1:0]         m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);
  localparam int LW = clog2(PACKET_MEM_BYTES) + 1;
  localparam int NW = AW + 1;
  localparam int RW = clog2(BW);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam int EW = DW + BW + 1;

  state_t        state_reg, state_next;
  logic [RW-1:0] rem_reg;
  logic [NW-1:0] words_reg, issued_reg, cap_idx_reg;
  logic [AW-1:0] addr_reg;
  logic [CW-1:0] outstanding_reg, fifo_count;
  logic          fwd_done_reg;

  logic [LW-1:0] len_clamp;
  logic [NW-1:0] words_calc;
  logic          credit_ok, pop, fifo_empty, cap_last;
  logic [DW-1:0] beat_data;
  logic [BW-1:0] last_keep, beat_keep;
  logic [EW-1:0] push_entry, pop_entry;

  assign len_clamp  = (fwd_byte_len > PLEN_WIDTH'(PACKET_MEM_BYTES)) ? LW'(PACKET_MEM_BYTES)
                                                                      : fwd_byte_len[LW-1:0];
  assign words_calc = NW'((len_clamp + LW'(BW - 1)) >> RW);

  // Everything requested but not yet popped must fit in the FIFO, so a push never overflows.
  assign credit_ok       = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign fwd_rd_en       = (state_reg == ST_ISSUE) && (issued_reg < words_reg) && credit_ok;
  assign fwd_addr        = addr_reg;
  assign rdy_for_fwd_ack = (state_reg == ST_ACK);
  assign fwd_done        = fwd_done_reg;

  for (genvar gi = 0; gi < BW; gi++) begin : g_byte
    assign beat_data[8*gi +: 8] = fwd_rd_data[DW-1-8*gi -: 8];
    assign last_keep[gi]        = (rem_reg == '0) || (RW'(gi) < rem_reg);
  end

  assign cap_last   = (cap_idx_reg == words_reg - NW'(1));
  assign beat_keep  = cap_last ? last_keep : '1;
  assign push_entry = {cap_last, beat_keep, beat_data};

  fwd_egress_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fwd_rd_data_vld),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (pop_entry),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = pop_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (rdy_for_fwd) state_next = ST_ACK;
      ST_ACK:   state_next = ST_LEN;
      ST_LEN:   state_next = (words_calc == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (fwd_rd_en && (issued_reg == words_reg - NW'(1))) state_next = ST_DRAIN;
      ST_DRAIN: if (pop && m_axis_tlast) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg         <= '0;
      words_reg       <= '0;
      issued_reg      <= '0;
      cap_idx_reg     <= '0;
      addr_reg        <= '0;
      outstanding_reg <= '0;
      fwd_done_reg    <= 1'b0;
    end else begin
      fwd_done_reg <= (state_reg == ST_DONE);
      if (state_reg == ST_LEN) begin
        rem_reg     <= len_clamp[RW-1:0];
        words_reg   <= words_calc;
        issued_reg  <= '0;
        cap_idx_reg <= '0;
        addr_reg    <= '0;
      end else begin
        if (fwd_rd_en) begin
          issued_reg <= issued_reg + NW'(1);
          addr_reg   <= addr_reg + AW'(1);
        end
        if (fwd_rd_data_vld) cap_idx_reg <= cap_idx_reg + NW'(1);
      end
      case ({fwd_rd_en, fwd_rd_data_vld})
        2'b10:   outstanding_reg <= outstanding_reg + CW'(1);
        2'b01:   outstanding_reg <= outstanding_reg - CW'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_axis_egress.sv
// Randomized bench for fwd_axis_egress with a fixed-latency core read model and a packet-level reference.
module tb_fwd_axis_egress;
  localparam int DW    = 64;
  localparam int BW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int MEMB  = 2048;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy_for_fwd = 1'b0;
  logic          rdy_for_fwd_ack;
  logic [31:0]   fwd_byte_len = '0;
  logic [AW-1:0] fwd_addr;
  logic          fwd_rd_en;
  logic [DW-1:0] fwd_rd_data;
  logic          fwd_rd_data_vld;
  logic          fwd_done;
  logic [DW-1:0] m_axis_tdata;
  logic [BW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;

  fwd_axis_egress dut (
    .clk            (clk),
    .rst            (rst),
    .rdy_for_fwd    (rdy_for_fwd),
    .rdy_for_fwd_ack(rdy_for_fwd_ack),
    .fwd_byte_len   (fwd_byte_len),
    .fwd_addr       (fwd_addr),
    .fwd_rd_en      (fwd_rd_en),
    .fwd_rd_data    (fwd_rd_data),
    .fwd_rd_data_vld(fwd_rd_data_vld),
    .fwd_done       (fwd_done),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core side: packet buffer bytes and a fixed-latency read pipe.
  logic [7:0]    mem [MEMB];
  logic [LAT-1:0] pipe_vld;
  logic [AW-1:0] pipe_addr [LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld     <= {pipe_vld[LAT-2:0], fwd_rd_en};
      pipe_addr[0] <= fwd_addr;
      for (int i = 1; i < LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  always_comb begin
    fwd_rd_data = '0;
    for (int j = 0; j < BW; j++)
      fwd_rd_data[DW-1-8*j -: 8] = mem[int'(pipe_addr[LAT-1]) * BW + j];
  end
  assign fwd_rd_data_vld = pipe_vld[LAT-1];

  // tready pattern: 0 = always ready, 1 = 1-0-0-1 repeating, 2 = random
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observation log filled at the falling edge.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t         beat_q[$];
  logic [AW-1:0] addr_q[$];
  int            ack_q[$];
  int            done_q[$];
  int            issued_n, popped_n, max_inflight, stall_viol, last_pop_cyc;
  logic          stalled;
  beat_t         held;

  always @(negedge clk) begin
    if (!rst) begin
      if (rdy_for_fwd_ack) ack_q.push_back(cyc);
      if (fwd_done) done_q.push_back(cyc);
      if (fwd_rd_en) addr_q.push_back(fwd_addr);
      if (issued_n + int'(fwd_rd_en) - popped_n > max_inflight)
        max_inflight = issued_n + int'(fwd_rd_en) - popped_n;
      if (stalled && (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tlast} != held))
        stall_viol++;
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        beat_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        popped_n++;
        last_pop_cyc = cyc;
      end
      if (fwd_rd_en) issued_n++;
    end
  end

  task automatic clear_log();
    beat_q.delete(); addr_q.delete(); ack_q.delete(); done_q.delete();
    issued_n = 0; popped_n = 0; max_inflight = 0; stall_viol = 0; last_pop_cyc = 0;
    stalled = 1'b0;
  endtask

  task automatic start_packet(input int len, output bit timed_out);
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    @(posedge clk); #1;
    clear_log();
    fwd_byte_len = 32'(len);
    rdy_for_fwd  = 1'b1;
    timed_out    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (ack_q.size() > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    rdy_for_fwd = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done_q.size() > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Full packet run with reference comparison against the buffer contents.
  task automatic test_packet(input int len, input int mode, input string name);
    bit    to1, to2;
    int    l_bytes, n_words, rem, nb;
    logic [BW-1:0] exp_keep;
    logic [DW-1:0] exp_data, mask;
    beat_t b;
    ready_mode = mode;
    start_packet(len, to1);
    wait_done(4000, to2);
    l_bytes = (len > MEMB) ? MEMB : len;
    n_words = (l_bytes + BW - 1) / BW;
    rem     = l_bytes % BW;

    checks++;
    if ((to1 | to2) !== 1'b0) begin
      failures++;
      $display("FAIL %s timeout: ack_timeout=%0b done_timeout=%0b required 0/0", name, to1, to2);
    end
    checks++;
    if (ack_q.size() !== 1) begin
      failures++;
      $display("FAIL %s ack_cycles: got %0d required 1", name, ack_q.size());
    end
    checks++;
    if (done_q.size() !== 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d required 1", name, done_q.size());
    end
    checks++;
    if (addr_q.size() !== n_words) begin
      failures++;
      $display("FAIL %s read_count: got %0d required %0d", name, addr_q.size(), n_words);
    end
    for (int i = 0; i < addr_q.size() && i < n_words; i++) begin
      checks++;
      if (addr_q[i] !== AW'(i)) begin
        failures++;
        $display("FAIL %s read_addr[%0d]: got %0d required %0d", name, i, addr_q[i], i);
      end
    end
    checks++;
    if (beat_q.size() !== n_words) begin
      failures++;
      $display("FAIL %s beat_count: got %0d required %0d", name, beat_q.size(), n_words);
    end
    nb = (beat_q.size() < n_words) ? beat_q.size() : n_words;
    for (int i = 0; i < nb; i++) begin
      exp_keep = (i == n_words - 1 && rem != 0) ? BW'((1 << rem) - 1) : '1;
      for (int k = 0; k < BW; k++) begin
        exp_data[8*k +: 8] = mem[i * BW + k];
        mask[8*k +: 8]     = {8{exp_keep[k]}};
      end
      b = beat_q[i];
      checks++;
      if ({b.data & mask, b.keep, b.last} !== {exp_data & mask, exp_keep, 1'(i == n_words - 1)}) begin
        failures++;
        $display("FAIL %s beat[%0d]: got data=%h keep=%h last=%0b required data=%h keep=%h last=%0b",
                 name, i, b.data & mask, b.keep, b.last, exp_data & mask, exp_keep, i == n_words - 1);
      end
    end
    checks++;
    if (max_inflight > DEPTH) begin
      failures++;
      $display("FAIL %s fifo_overflow: in-flight words got %0d required <= %0d", name, max_inflight, DEPTH);
    end
    checks++;
    if (stall_viol !== 0) begin
      failures++;
      $display("FAIL %s stall_stability: changes while stalled got %0d required 0", name, stall_viol);
    end
    if (n_words > 0 && done_q.size() > 0) begin
      checks++;
      if (done_q[0] <= last_pop_cyc) begin
        failures++;
        $display("FAIL %s done_order: done cycle %0d required after last beat cycle %0d",
                 name, done_q[0], last_pop_cyc);
      end
    end
    $display("packet %s len=%0d beats=%0d reads=%0d done=%0d", name, len, beat_q.size(), addr_q.size(), done_q.size());
  endtask

  task automatic test_reset();
    logic [AW+DW+BW+5-1:0] outs;
    repeat (3) @(posedge clk);
    #1;
    outs = {rdy_for_fwd_ack, fwd_rd_en, fwd_addr, fwd_done, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    outs = {rdy_for_fwd_ack, fwd_rd_en, fwd_addr, fwd_done, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL idle_outputs: got %h required 0", outs);
    end
    $display("reset: outputs=%h", outs);
  endtask

  task automatic test_short();
    test_packet(20, 0, "len20");
    test_packet(16, 0, "len16");
  endtask

  task automatic test_backpressure();
    test_packet(64, 1, "len64_bp");
  endtask

  task automatic test_zero_length();
    test_packet(0, 0, "len0");
    if (ack_q.size() > 0 && done_q.size() > 0) begin
      checks++;
      if (done_q[0] - ack_q[0] !== 3) begin
        failures++;
        $display("FAIL len0 done_latency: ack-to-done got %0d cycles required 3", done_q[0] - ack_q[0]);
      end
    end
  endtask

  task automatic test_saturate();
    test_packet(5000, 0, "len5000");
  endtask

  task automatic test_reset_mid();
    bit to;
    bit reached;
    logic [AW+DW+BW+5-1:0] outs;
    ready_mode = 0;
    start_packet(64, to);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (popped_n >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if ((to | !reached) !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid setup: ack_timeout=%0b beat2_reached=%0b required 0/1", to, reached);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    outs = {rdy_for_fwd_ack, fwd_rd_en, fwd_addr, fwd_done, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL rst_mid async_outputs: got %h required 0", outs);
    end
    clear_log();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if ({done_q.size(), beat_q.size()} !== {32'd0, 32'd0}) begin
      failures++;
      $display("FAIL rst_mid abandoned: done=%0d beats=%0d required 0/0", done_q.size(), beat_q.size());
    end
    $display("reset mid-packet: outputs=%h", outs);
    test_packet(8, 0, "post_rst_len8");
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      test_packet(int'($urandom_range(0, 300)), 2, $sformatf("rand%0d", p));
    end
    test_packet(int'($urandom_range(1, 200)), 1, "rand_bp");
  endtask

  initial begin
    test_reset();
    test_short();
    test_backpressure();
    test_zero_length();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
